// File: rtl/axi4_mem_dp_if.sv
// axi4_mem_dp_if: request/response bundle for the dual-port memory
// master drives requests, slave (the memory) drives responses
interface axi4_mem_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_err;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    rd_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_strb,
    output rd_en, rd_addr,
    input  wr_err, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_strb,
    input  rd_en, rd_addr,
    output wr_err, rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/axi4_mem_dp.sv
// axi4_mem_dp: simple dual-port byte-strobed memory
// one write port, one read port, 1- or 2-cycle read pipeline
module axi4_mem_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic         clk,
  input  logic         rst,
  axi4_mem_dp_if.slave bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH);

  // 2-state storage powers up as all-zero;
  // reset never touches it
  bit   [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_oor;
  logic                  rd_oor;
  logic                  wr_go;
  logic                  same_addr;
  logic [DATA_WIDTH-1:0] wr_cur;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_err_q, s1_err_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  wr_err_q, wr_err_d;

  // Range checks, strobe merge and read-word select
  always_comb begin
    wr_oor    = {1'b0, bus.wr_addr} >= LIMIT;
    rd_oor    = {1'b0, bus.rd_addr} >= LIMIT;
    wr_go     = bus.wr_en && !wr_oor && !rst;
    same_addr = wr_go && (bus.wr_addr == bus.rd_addr);
    wr_cur    = wr_oor ? '0 : mem[bus.wr_addr];
    wr_merged = wr_cur;
    for (int i = 0; i < SW; i++) begin
      if (bus.wr_strb[i]) begin
        wr_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
    if (rd_oor) begin
      rd_word = '0;
    end else if (RDW_MODE == 1 && same_addr) begin
      rd_word = wr_merged;
    end else begin
      rd_word = mem[bus.rd_addr];
    end
  end

  // Commit strobed bytes of an in-range write
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int i = 0; i < SW; i++) begin
        if (bus.wr_strb[i]) begin
          mem[bus.wr_addr][8*i +: 8] <=
            bus.wr_data[8*i +: 8];
        end
      end
    end
  end

  // Next state for stage 1 and the write error flag;
  // data holds when no read is issued
  always_comb begin
    s1_valid_d = bus.rd_en;
    s1_err_d   = bus.rd_en && rd_oor;
    s1_data_d  = bus.rd_en ? rd_word : s1_data_q;
    wr_err_d   = bus.wr_en && wr_oor;
  end

  // Stage 1 and write error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s1_data_q  <= s1_data_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign bus.wr_err = wr_err_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_q, s2_valid_d;
      logic                  s2_err_q, s2_err_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      // Stage 2 advances only on a valid stage-1 entry
      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_err_d   = s1_valid_q && s1_err_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      // Stage 2 registers
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_err_q   <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_err_q   <= s2_err_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign bus.rd_valid = s2_valid_q;
      assign bus.rd_err   = s2_err_q;
      assign bus.rd_data  = s2_data_q;
    end else begin : g_lat1
      assign bus.rd_valid = s1_valid_q;
      assign bus.rd_err   = s1_err_q;
      assign bus.rd_data  = s1_data_q;
    end
  endgenerate
endmodule

// File: tb/tb_axi4_mem_dp.sv
// tb_axi4_mem_dp: two configurations driven in lockstep
// A: latency 1 / old-data, B: latency 2 / new-data
module tb_axi4_mem_dp;
  localparam int DEPTH = 1000;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_en;
  logic [9:0]  rd_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int RL  [2] = '{1, 2};
  int RDW [2] = '{0, 1};

  logic [31:0] mem_m [DEPTH];
  resp_t       pq [2][$];
  logic [31:0] last [2];

  logic [1:0]  e_v, e_e;
  logic [31:0] e_d [2];
  logic        e_werr;

  logic [1:0]  o_v, o_e, o_werr;
  logic [31:0] o_d [2];

  always #5 clk = ~clk;

  axi4_mem_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) ia ();
  axi4_mem_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) ib ();

  assign ia.wr_en = wr_en;   assign ib.wr_en = wr_en;
  assign ia.wr_addr = wr_addr; assign ib.wr_addr = wr_addr;
  assign ia.wr_data = wr_data; assign ib.wr_data = wr_data;
  assign ia.wr_strb = wr_strb; assign ib.wr_strb = wr_strb;
  assign ia.rd_en = rd_en;   assign ib.rd_en = rd_en;
  assign ia.rd_addr = rd_addr; assign ib.rd_addr = rd_addr;

  assign o_v    = {ib.rd_valid, ia.rd_valid};
  assign o_e    = {ib.rd_err, ia.rd_err};
  assign o_werr = {ib.wr_err, ia.wr_err};
  assign o_d[0] = ia.rd_data;
  assign o_d[1] = ib.rd_data;

  axi4_mem_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(DEPTH),
    .READ_LATENCY(1), .RDW_MODE(0)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));

  axi4_mem_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(DEPTH),
    .READ_LATENCY(2), .RDW_MODE(1)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  // Reference model: advance one clock, then predict outputs
  task automatic tick();
    resp_t       r;
    logic [31:0] mrg;
    logic        oor_w, oor_r, was_rst, werr_n;
    oor_w = int'(wr_addr) >= DEPTH;
    oor_r = int'(rd_addr) >= DEPTH;
    mrg = oor_w ? 32'h0 : mem_m[wr_addr];
    for (int b = 0; b < 4; b++)
      if (wr_strb[b]) mrg[8*b +: 8] = wr_data[8*b +: 8];
    for (int k = 0; k < 2; k++) begin
      if (rst) pq[k].delete();
      else if (rd_en) begin
        r.due = cyc + RL[k];
        r.err = oor_r;
        if (oor_r) r.data = 32'h0;
        else if (RDW[k] == 1 && wr_en && wr_addr == rd_addr)
          r.data = mrg;
        else r.data = mem_m[rd_addr];
        pq[k].push_back(r);
      end
    end
    werr_n  = !rst && wr_en && oor_w;
    was_rst = rst;
    if (!rst && wr_en && !oor_w) mem_m[wr_addr] = mrg;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    e_werr = werr_n;
    for (int k = 0; k < 2; k++) begin
      if (was_rst) last[k] = 32'h0;
      if (pq[k].size() != 0 && pq[k][0].due == cyc) begin
        e_v[k] = 1'b1;
        e_e[k] = pq[k][0].err;
        e_d[k] = pq[k][0].data;
        last[k] = e_d[k];
        void'(pq[k].pop_front());
      end else begin
        e_v[k] = 1'b0;
        e_e[k] = 1'b0;
        e_d[k] = last[k];
      end
    end
  endtask

  task automatic write(input logic [9:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
  endtask

  // Issue one read; capture A after 1 cycle, B after 2
  task automatic read_word(input logic [9:0] a,
                           output logic [31:0] da, db,
                           output logic va, vb, ea, eb,
                           output logic vb_early, va_late);
    rd_en = 1'b1; rd_addr = a;
    tick();
    va = o_v[0]; da = o_d[0]; ea = o_e[0];
    vb_early = o_v[1];
    tick();
    vb = o_v[1]; db = o_d[1]; eb = o_e[1];
    va_late = o_v[0];
  endtask

  task automatic test_reset();
    logic [31:0] da, db;
    logic va, vb, ea, eb, vbe, val;
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1; rd_en = i[0]; rd_addr = 10'd5;
      wr_en = 1'b1; wr_addr = 10'd5;
      wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF;
      tick();
      n_tests++;
      if ({o_v, o_e, o_werr, o_d[0], o_d[1]} !== 70'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got v=%b e=%b we=%b d0=%h d1=%h want all 0",
                 i, o_v, o_e, o_werr, o_d[0], o_d[1]);
      end
    end
    read_word(10'd5, da, db, va, vb, ea, eb, vbe, val);
    n_tests++;
    if ({va, ea, da, vbe} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_read_a got v=%b e=%b d=%h b_early=%b want v=1 e=0 d=0 b_early=0",
               va, ea, da, vbe);
    end
    n_tests++;
    if ({vb, eb, db, val} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_read_b got v=%b e=%b d=%h a_late=%b want v=1 e=0 d=0 a_late=0",
               vb, eb, db, val);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] da, db;
    logic va, vb, ea, eb, vbe, val;
    write(10'd7, 32'hAABB_CCDD, 4'hF);
    write(10'd7, 32'h1122_3344, 4'b0101);
    read_word(10'd7, da, db, va, vb, ea, eb, vbe, val);
    n_tests++;
    if ({va, vb, da, db} !== {2'b11, 32'hAA22_CC44, 32'hAA22_CC44}) begin
      n_fail++;
      $display("FAIL strobe_merge got va=%b vb=%b da=%h db=%h want 1 1 aa22cc44",
               va, vb, da, db);
    end
    write(10'd7, 32'h0, 4'h0);
    n_tests++;
    if (o_werr !== 2'b00) begin
      n_fail++;
      $display("FAIL strobe_zero_err got %b want 00", o_werr);
    end
    read_word(10'd7, da, db, va, vb, ea, eb, vbe, val);
    n_tests++;
    if ({da, db} !== {32'hAA22_CC44, 32'hAA22_CC44}) begin
      n_fail++;
      $display("FAIL strobe_zero got da=%h db=%h want aa22cc44", da, db);
    end
  endtask

  task automatic test_collision();
    write(10'd3, 32'h0, 4'hF);
    wr_en = 1'b1; wr_addr = 10'd3;
    wr_data = 32'hDEAD_BEEF; wr_strb = 4'hF;
    rd_en = 1'b1; rd_addr = 10'd3;
    tick();
    n_tests++;
    if ({o_v[0], o_d[0]} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL rdw_old got v=%b d=%h want 1 00000000",
               o_v[0], o_d[0]);
    end
    rd_en = 1'b1; rd_addr = 10'd3;
    tick();
    n_tests++;
    if ({o_v, o_d[0], o_d[1]} !== {2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL rdw_new got v=%b da=%h db=%h want 11 deadbeef deadbeef",
               o_v, o_d[0], o_d[1]);
    end
    tick();
    n_tests++;
    if ({o_v[1], o_d[1], o_v[0]} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL rdw_next_b got vb=%b db=%h va=%b want 1 deadbeef 0",
               o_v[1], o_d[1], o_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [2][$];
    int first [2], lastc [2];
    for (int i = 0; i < 16; i++)
      write(10'(i), 32'h100 + 32'(i), 4'hF);
    for (int k = 0; k < 2; k++) begin
      got[k].delete(); first[k] = -1; lastc[k] = -1;
    end
    for (int c = 0; c < 19; c++) begin
      if (c < 16) begin rd_en = 1'b1; rd_addr = 10'(c); end
      tick();
      for (int k = 0; k < 2; k++) if (o_v[k]) begin
        got[k].push_back(o_d[k]);
        if (first[k] < 0) first[k] = c;
        lastc[k] = c;
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (got[k].size() != 16 || lastc[k] - first[k] != 15
          || first[k] != RL[k] - 1) begin
        n_fail++;
        $display("FAIL b2b_count dut=%0d got n=%0d span=%0d first=%0d want 16 15 %0d",
                 k, got[k].size(), lastc[k] - first[k], first[k], RL[k] - 1);
      end
      for (int i = 0; i < got[k].size(); i++) begin
        n_tests++;
        if (got[k][i] !== 32'h100 + 32'(i)) begin
          n_fail++;
          $display("FAIL b2b_data dut=%0d i=%0d got %h want %h",
                   k, i, got[k][i], 32'h100 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] da, db;
    logic va, vb, ea, eb, vbe, val;
    write(10'd1010, 32'hFFFF_FFFF, 4'hF);
    n_tests++;
    if (o_werr !== 2'b11) begin
      n_fail++;
      $display("FAIL oor_wr_err got %b want 11", o_werr);
    end
    tick();
    n_tests++;
    if (o_werr !== 2'b00) begin
      n_fail++;
      $display("FAIL oor_wr_err_width got %b want 00", o_werr);
    end
    for (int a = 0; a <= DEPTH; a++) begin
      if (a < DEPTH) begin rd_en = 1'b1; rd_addr = 10'(a); end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if ({o_v[k], o_e[k], o_d[k]} !== {e_v[k], e_e[k], e_d[k]}) begin
          n_fail++;
          $display("FAIL oor_alias dut=%0d a=%0d got v=%b d=%h want v=%b d=%h",
                   k, a, o_v[k], o_d[k], e_v[k], e_d[k]);
        end
      end
    end
    read_word(10'd1010, da, db, va, vb, ea, eb, vbe, val);
    n_tests++;
    if ({va, ea, da, vb, eb, db} !== {2'b11, 32'h0, 2'b11, 32'h0}) begin
      n_fail++;
      $display("FAIL oor_rd got va=%b ea=%b da=%h vb=%b eb=%b db=%h want 1 1 0",
               va, ea, da, vb, eb, db);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] da, db;
    logic va, vb, ea, eb, vbe, val;
    write(10'd20, 32'h1234_5678, 4'hF);
    rd_en = 1'b1; rd_addr = 10'd20;
    tick();
    n_tests++;
    if ({o_v, o_d[0]} !== {2'b01, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL rmr_n1 got v=%b da=%h want 01 12345678", o_v, o_d[0]);
    end
    rst = 1'b1; rd_en = 1'b1; rd_addr = 10'd20;
    tick();
    n_tests++;
    if ({o_v, o_d[0], o_d[1]} !== 66'h0) begin
      n_fail++;
      $display("FAIL rmr_n2 got v=%b da=%h db=%h want 0", o_v, o_d[0], o_d[1]);
    end
    tick();
    n_tests++;
    if (o_v !== 2'b00) begin
      n_fail++;
      $display("FAIL rmr_n3 got v=%b want 00", o_v);
    end
    read_word(10'd20, da, db, va, vb, ea, eb, vbe, val);
    n_tests++;
    if ({va, vb, da, db} !== {2'b11, 32'h1234_5678, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL rmr_keep got da=%h db=%h want 12345678", da, db);
    end
  endtask

  function automatic logic [9:0] pick_addr();
    if ($urandom_range(0, 9) == 0)
      return 10'($urandom_range(DEPTH, 1023));
    return 10'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 39) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = pick_addr();
      wr_data = $urandom;
      wr_strb = 4'($urandom_range(0, 15));
      if (int'(wr_addr) >= DEPTH && wr_strb == 4'h0) wr_strb = 4'hF;
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = pick_addr();
      tick();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if ({o_v[k], o_e[k], o_d[k]} !== {e_v[k], e_e[k], e_d[k]}) begin
          n_fail++;
          $display("FAIL random_rd c=%0d dut=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                   c, k, o_v[k], o_e[k], o_d[k], e_v[k], e_e[k], e_d[k]);
        end
      end
      n_tests++;
      if (o_werr !== {2{e_werr}}) begin
        n_fail++;
        $display("FAIL random_wr_err c=%0d got %b want %b", c, o_werr, {2{e_werr}});
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; wr_strb = '0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    last[0] = 32'h0; last[1] = 32'h0;
    test_reset();
    test_strobes();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
